// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-back forwarding, post-reset clear sweep
// and an optional busy scoreboard enabled by REGFILE_SCOREBOARD_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  issue_v,
  input  logic [ADDR_W-1:0]     issue_addr,
  output logic [NRD-1:0]        rbusy
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic run, wr0, wr1;
  assign run = state_q == RUN;
  assign wr0 = run && we0 && !(ZERO_REG != 0 && waddr0 == '0);
  assign wr1 = run && we1 && !(ZERO_REG != 0 && waddr1 == '0);
  assign ready = ready_q;
  // Sweep clears one register per cycle; the last one flips the FSM into RUN.
  always_comb begin
    state_d = rst ? INIT : (!run && &cnt_q) ? RUN : state_q;
    cnt_d = (rst || run) ? '0 : cnt_q + 1'b1;
    ready_d = !rst && (run || &cnt_q);
    regs_d = regs_q;
    if (!rst && !run) regs_d[cnt_q] = '0;
    if (wr0) regs_d[waddr0] = wdata0;
    if (wr1) regs_d[waddr1] = wdata1;
  end
`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q, busy_d;
  // Issue is applied after the clears so a new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[waddr0] = 1'b0;
    if (we1) busy_d[waddr1] = 1'b0;
    if (issue_v) busy_d[issue_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    if (rst || !run) busy_d = '0;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{issue_v, issue_addr};
`endif
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    ready_q <= ready_d;
    regs_q <= regs_d;
`ifdef REGFILE_SCOREBOARD_EN
    busy_q <= busy_d;
`endif
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic f0, f1;
    assign ra = raddr[i*ADDR_W +: ADDR_W];
    assign f1 = we1 && waddr1 == ra;
    assign f0 = we0 && waddr0 == ra;
    assign rdata[i*DATA_W +: DATA_W] = (!run || !re[i] || (ZERO_REG != 0 && ra == '0)) ? '0 :
                                       f1 ? wdata1 : f0 ? wdata0 : regs_q[ra];
`ifdef REGFILE_SCOREBOARD_EN
    assign rbusy[i] = run && re[i] && busy_q[ra] && !f1 && !f0;
`else
    assign rbusy[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard-driven bench for regfile_mp (default parameters).
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  logic ready;
  logic we0, we1;
  logic [4:0] waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0] re;
  logic [9:0] raddr;
  logic [63:0] rdata;
  logic issue_v;
  logic [4:0] issue_addr;
  logic [1:0] rbusy;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  regfile_mp dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata),
    .issue_v(issue_v), .issue_addr(issue_addr), .rbusy(rbusy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    re = 0; raddr = 0; issue_v = 0; issue_addr = 0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    raddr[p*5 +: 5] = a;
    re[p] = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    idle(); rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    rst = 0; we0 = 1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5; rd(0, 5'd3);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (n == 5) begin
        exp_q.push_back(32'h0);
        tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL init_rdata: got %h expected %h", rdata[31:0], e); end
      end
      if (ready) break;
    end
    we0 = 0;
    tests++; if (n !== 32) begin fails++; $display("FAIL init_sweep_len: got %0d expected 32", n); end
    exp_q.push_back(32'h0); #1;
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL init_no_write: got %h expected %h", rdata[31:0], e); end
  endtask

  task automatic test_basic();
    @(negedge clk); idle(); we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    @(negedge clk); idle(); rd(1, 5'd5); rd(0, 5'd5);
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF); #1;
    tests++; e = exp_q.pop_front(); if (rdata[63:32] !== e) begin fails++; $display("FAIL basic_p1: got %h expected %h", rdata[63:32], e); end
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL basic_p0: got %h expected %h", rdata[31:0], e); end
    re = 2'b01; exp_q.push_back(32'h0); #1;
    tests++; e = exp_q.pop_front(); if (rdata[63:32] !== e) begin fails++; $display("FAIL basic_re0: got %h expected %h", rdata[63:32], e); end
  endtask

  task automatic test_collision();
    @(negedge clk); idle();
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    rd(0, 5'd7); rd(1, 5'd7);
    exp_q.push_back(32'h22222222); exp_q.push_back(32'h22222222); #1;
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL coll_fwd_p0: got %h expected %h", rdata[31:0], e); end
    tests++; e = exp_q.pop_front(); if (rdata[63:32] !== e) begin fails++; $display("FAIL coll_fwd_p1: got %h expected %h", rdata[63:32], e); end
    @(negedge clk); we0 = 0; we1 = 0;
    exp_q.push_back(32'h22222222); #1;
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL coll_stored: got %h expected %h", rdata[31:0], e); end
    @(negedge clk); we0 = 1; waddr0 = 5'd8; wdata0 = 32'h33333333; rd(1, 5'd8);
    exp_q.push_back(32'h33333333); exp_q.push_back(32'h22222222); #1;
    tests++; e = exp_q.pop_front(); if (rdata[63:32] !== e) begin fails++; $display("FAIL fwd0_p1: got %h expected %h", rdata[63:32], e); end
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL fwd0_indep_p0: got %h expected %h", rdata[31:0], e); end
    @(negedge clk); we0 = 0;
    exp_q.push_back(32'h33333333); #1;
    tests++; e = exp_q.pop_front(); if (rdata[63:32] !== e) begin fails++; $display("FAIL fwd0_stored: got %h expected %h", rdata[63:32], e); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk); idle(); we1 = 1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; rd(0, 5'd0);
    exp_q.push_back(32'h0); #1;
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL zero_same: got %h expected %h", rdata[31:0], e); end
    @(negedge clk); we1 = 0; we0 = 1; waddr0 = 5'd0; wdata0 = 32'h12345678;
    @(negedge clk); we0 = 0;
    exp_q.push_back(32'h0); #1;
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL zero_later: got %h expected %h", rdata[31:0], e); end
  endtask

  task automatic test_scoreboard();
`ifdef REGFILE_SCOREBOARD_EN
    @(negedge clk); idle(); issue_v = 1; issue_addr = 5'd9; rd(0, 5'd9); raddr[9:5] = 5'd9; #1;
    tests++; if (rbusy !== 2'b00) begin fails++; $display("FAIL sb_before_edge: got %b expected 00", rbusy); end
    @(negedge clk); issue_v = 0; #1;
    tests++; if (rbusy !== 2'b01) begin fails++; $display("FAIL sb_busy: got %b expected 01", rbusy); end
    @(negedge clk); we0 = 1; waddr0 = 5'd9; wdata0 = 32'h99999999;
    exp_q.push_back(32'h99999999); #1;
    tests++; if (rbusy[0] !== 1'b0) begin fails++; $display("FAIL sb_fwd_clear: got %b expected 0", rbusy[0]); end
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL sb_fwd_data: got %h expected %h", rdata[31:0], e); end
    @(negedge clk); we0 = 0; #1;
    tests++; if (rbusy[0] !== 1'b0) begin fails++; $display("FAIL sb_cleared: got %b expected 0", rbusy[0]); end
    @(negedge clk); issue_v = 1; issue_addr = 5'd9; we0 = 1; waddr0 = 5'd9;
    @(negedge clk); issue_v = 0; we0 = 0; #1;
    tests++; if (rbusy[0] !== 1'b1) begin fails++; $display("FAIL sb_set_wins: got %b expected 1", rbusy[0]); end
    @(negedge clk); we1 = 1; waddr1 = 5'd9; wdata1 = 32'h9A9A9A9A; #1;
    tests++; if (rbusy[0] !== 1'b0) begin fails++; $display("FAIL sb_fwd1_clear: got %b expected 0", rbusy[0]); end
    @(negedge clk); we1 = 0; issue_v = 1; issue_addr = 5'd0; rd(1, 5'd0);
    @(negedge clk); issue_v = 0; #1;
    tests++; if (rbusy !== 2'b00) begin fails++; $display("FAIL sb_zero_reg: got %b expected 00", rbusy); end
    @(negedge clk); issue_v = 1; issue_addr = 5'd9;
    @(negedge clk); issue_v = 0; #1;
    tests++; if (rbusy[0] !== 1'b1) begin fails++; $display("FAIL sb_reissue: got %b expected 1", rbusy[0]); end
`else
    @(negedge clk); idle(); issue_v = 1; issue_addr = 5'd9; rd(0, 5'd9); rd(1, 5'd9);
    @(negedge clk); issue_v = 0; #1;
    tests++; if (rbusy !== 2'b00) begin fails++; $display("FAIL sb_off_tied: got %b expected 00", rbusy); end
`endif
  endtask

  task automatic test_sweep();
    int n;
    for (int a = 1; a < 32; a++) begin
      @(negedge clk); idle(); we0 = 1; waddr0 = 5'(a); wdata0 = 32'h01010101 * a;
    end
    @(negedge clk); idle(); rd(0, 5'd17);
    exp_q.push_back(32'h11111111); #1;
    tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL sweep_preload: got %h expected %h", rdata[31:0], e); end
    @(negedge clk); rst = 1; we0 = 1; waddr0 = 5'd5; wdata0 = 32'hCAFE0005;
    @(negedge clk); rst = 0;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL sweep_ready_low: got %b expected 0", ready); end
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (ready) break;
    end
    we0 = 0;
    tests++; if (n !== 32) begin fails++; $display("FAIL sweep_len: got %0d expected 32", n); end
    for (int a = 0; a < 32; a++) begin
      raddr[4:0] = 5'(a); exp_q.push_back(32'h0); #1;
      tests++; e = exp_q.pop_front(); if (rdata[31:0] !== e) begin fails++; $display("FAIL sweep_clear_r%0d: got %h expected %h", a, rdata[31:0], e); end
    end
    raddr[4:0] = 5'd9; #1;
    tests++; if (rbusy[0] !== 1'b0) begin fails++; $display("FAIL sweep_busy_clear: got %b expected 0", rbusy[0]); end
  endtask

  task automatic test_mid_reset();
    int n;
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); rst = 0;
    repeat (10) @(posedge clk);
    #1; rst = 1;
    @(posedge clk);
    @(negedge clk); rst = 0;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_ready_low: got %b expected 0", ready); end
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (ready) break;
    end
    tests++; if (n !== 32) begin fails++; $display("FAIL mid_sweep_len: got %0d expected 32", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_sweep();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
